// File: rtl/ddr_wr.sv
// rtl/ddr_wr.sv - capture-path DDR write master
// Packs 32-bit pixels into 256-bit words, buffers them, and issues one data beat plus one write command per word.
module ddr_wr #(
  parameter int WORDS_PER_LINE = 30,
  parameter int LINES          = 160,
  parameter int ADDR_STEP      = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init_calib_complete,
  input  logic         frame_start,
  input  logic         pix_valid,
  input  logic [31:0]  pix_data,
  input  logic         ddr_cmd_rdy,
  output logic [2:0]   ddr_cmd,
  output logic         ddr_cmd_en,
  output logic [28:0]  ddr_wr_addr,
  input  logic         ddr_wr_data_rdy,
  output logic [255:0] ddr_wr_data,
  output logic         ddr_wr_data_en,
  output logic         ddr_wr_data_end,
  output logic [31:0]  ddr_wr_data_mask,
  output logic         frame_done,
  output logic         overflow
);

  localparam int FRAME_WORDS = WORDS_PER_LINE * LINES;
  localparam int WCNT_W      = $clog2(FRAME_WORDS);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);
  localparam logic [28:0]       STEP      = 29'(ADDR_STEP);
  localparam logic [PTR_W:0]    DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, CMD} state_t;

  state_t              state_q, state_d;
  logic [2:0]          pack_cnt_q, pack_cnt_d;
  logic [255:0]        pack_buf_q, pack_buf_d;
  logic [255:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [255:0]        data_q, data_d;
  logic [28:0]         addr_q, addr_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                restart_q, restart_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;

  logic                pix_acc, word_done, fifo_full, fifo_empty;
  logic                push, pop, data_xfer, cmd_xfer;
  logic [2:0]          pack_base;
  logic [255:0]        pack_word;

  assign fifo_full  = (count_q == DEPTH);
  assign fifo_empty = (count_q == '0);
  assign data_xfer  = (state_q == DATA) && ddr_wr_data_rdy;
  assign cmd_xfer   = (state_q == CMD) && ddr_cmd_rdy;

  // frame_start clears the packer before the same-cycle pixel is stored as pixel 0.
  always_comb begin
    pix_acc    = pix_valid && init_calib_complete;
    pack_base  = frame_start ? 3'd0 : pack_cnt_q;
    pack_word  = pack_buf_q;
    pack_word[{pack_base, 5'b0} +: 32] = pix_data;
    word_done  = pix_acc && (pack_base == 3'd7);
    pack_cnt_d = pix_acc ? pack_base + 3'd1 : pack_base;
    pack_buf_d = pix_acc ? pack_word : pack_buf_q;
    push       = word_done && !fifo_full;
    overflow_d = overflow_q || (word_done && fifo_full);
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    data_d       = data_q;
    addr_d       = addr_q;
    wcnt_d       = wcnt_q;
    restart_d    = restart_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && init_calib_complete && !frame_start) begin
          pop     = 1'b1;
          data_d  = fifo_mem_q[rptr_q];
          state_d = DATA;
        end
        if (frame_start) begin
          addr_d = '0;
          wcnt_d = '0;
        end
      end
      DATA: begin
        if (data_xfer) state_d = CMD;
        if (frame_start) restart_d = 1'b1;
      end
      CMD: begin
        if (cmd_xfer) begin
          state_d   = IDLE;
          restart_d = 1'b0;
          if (restart_q || frame_start || wcnt_q == LAST_WORD) begin
            addr_d       = '0;
            wcnt_d       = '0;
            frame_done_d = (wcnt_q == LAST_WORD) && !restart_q;
          end else begin
            addr_d = addr_q + STEP;
            wcnt_d = wcnt_q + 1'b1;
          end
        end else if (frame_start) begin
          restart_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (frame_start) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wptr_q] <= pack_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pack_cnt_q   <= '0;
      pack_buf_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      wcnt_q       <= '0;
      restart_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pack_cnt_q   <= pack_cnt_d;
      pack_buf_q   <= pack_buf_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      wcnt_q       <= wcnt_d;
      restart_q    <= restart_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign ddr_cmd          = 3'd0;
  assign ddr_cmd_en       = cmd_xfer;
  assign ddr_wr_addr      = addr_q;
  assign ddr_wr_data      = data_q;
  assign ddr_wr_data_en   = data_xfer;
  assign ddr_wr_data_end  = data_xfer;
  assign ddr_wr_data_mask = 32'd0;
  assign frame_done       = frame_done_q;
  assign overflow         = overflow_q;

endmodule
